// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction cache: word width,
// default geometry and FSM state encodings.
package icache_pkg;

  localparam int unsigned WORD_W                = 32;
  localparam int unsigned ICACHE_INDEX_BIT_DEF  = 4;  // 16 lines
  localparam int unsigned ICACHE_OFFSET_BIT_DEF = 2;  // 4 words (16 bytes) per line

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
//   fetch : inst_req, pc, clear        -> cache
//           inst_ready, inst, mem_busy <- cache
//   memory: miss_req, miss_addr        <- cache
//           miss_ready, miss_data      -> cache
// slave  = the cache, master = instruction unit / memory unit / bench.
interface icache_if;

  logic                          inst_req;
  logic [icache_pkg::WORD_W-1:0] pc;
  logic                          clear;
  logic                          inst_ready;
  logic [icache_pkg::WORD_W-1:0] inst;
  logic                          mem_busy;
  logic                          miss_req;
  logic [icache_pkg::WORD_W-1:0] miss_addr;
  logic                          miss_ready;
  logic [icache_pkg::WORD_W-1:0] miss_data;

  modport slave (
    input  inst_req, pc, clear, miss_ready, miss_data,
    output inst_ready, inst, mem_busy, miss_req, miss_addr
  );

  modport master (
    output inst_req, pc, clear, miss_ready, miss_data,
    input  inst_ready, inst, mem_busy, miss_req, miss_addr
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with register-based tag/data arrays.
// Hits are answered combinationally in IDLE; a miss refills the whole line
// one word at a time through the miss_req/miss_ready handshake.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (freeze all state when low)
//   bus    : icache_if.slave (fetch request/response and refill handshake)
//   hit_cnt, miss_cnt : statistics counters, only with ICACHE_STATS_EN
// Optional feature macro: ICACHE_STATS_EN.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned ICACHE_INDEX_BIT  = ICACHE_INDEX_BIT_DEF,
  parameter int unsigned ICACHE_OFFSET_BIT = ICACHE_OFFSET_BIT_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  icache_if.slave           bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [WORD_W-1:0] hit_cnt,
  output logic [WORD_W-1:0] miss_cnt
`endif
);

  localparam int unsigned LINES  = 1 << ICACHE_INDEX_BIT;
  localparam int unsigned WORDS  = 1 << ICACHE_OFFSET_BIT;
  localparam int unsigned LINE_W = WORD_W - ICACHE_OFFSET_BIT - 2;
  localparam int unsigned TAG_W  = LINE_W - ICACHE_INDEX_BIT;
  localparam logic [ICACHE_OFFSET_BIT-1:0] LAST_WORD = ICACHE_OFFSET_BIT'(WORDS - 1);

  icache_state_e                state;
  logic [ICACHE_OFFSET_BIT-1:0] cnt;
  logic [LINE_W-1:0]            base_line;  // line address of the refill in flight
  logic [LINES-1:0]             valid;
  logic [TAG_W-1:0]             tag_arr  [LINES];
  logic [WORD_W-1:0]            data_arr [LINES][WORDS];

  logic [ICACHE_OFFSET_BIT-1:0] pc_off;
  logic [ICACHE_INDEX_BIT-1:0]  pc_idx;
  logic [ICACHE_INDEX_BIT-1:0]  fill_idx;
  logic [TAG_W-1:0]             pc_tag;
  logic [TAG_W-1:0]             fill_tag;
  logic                         hit;
  logic                         miss_start;
  logic                         fill_word;

  // Address split; pc[1:0] is ignored.
  assign pc_off   = bus.pc[ICACHE_OFFSET_BIT+1 : 2];
  assign pc_idx   = bus.pc[ICACHE_INDEX_BIT+ICACHE_OFFSET_BIT+1 : ICACHE_OFFSET_BIT+2];
  assign pc_tag   = bus.pc[WORD_W-1 : ICACHE_INDEX_BIT+ICACHE_OFFSET_BIT+2];
  assign fill_idx = base_line[ICACHE_INDEX_BIT-1:0];
  assign fill_tag = base_line[LINE_W-1 : ICACHE_INDEX_BIT];

  // Hit only in IDLE; clear masks the response without touching state.
  assign hit = bus.inst_req && (state == IDLE) && valid[pc_idx] &&
               (tag_arr[pc_idx] == pc_tag) && !bus.clear;

  assign miss_start = bus.inst_req && (state == IDLE) && !hit && !bus.clear && rdy_in;
  assign fill_word  = rdy_in && (state == REFILL) && bus.miss_ready;

  assign bus.inst_ready = hit;
  assign bus.inst       = hit ? data_arr[pc_idx][pc_off] : '0;
  assign bus.mem_busy   = (state == REFILL);
  assign bus.miss_req   = (state == REFILL);
  assign bus.miss_addr  = {base_line, cnt, 2'b00};

  // Control FSM: line fetch sequencing and valid bits.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      cnt       <= '0;
      base_line <= '0;
      valid     <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            base_line      <= bus.pc[WORD_W-1 : ICACHE_OFFSET_BIT+2];
            valid[pc_idx]  <= 1'b0;
            cnt            <= '0;
            state          <= REFILL;
          end
        end
        REFILL: begin
          if (bus.miss_ready) begin
            cnt <= cnt + ICACHE_OFFSET_BIT'(1);
            if (cnt == LAST_WORD) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage; deliberately not reset, valid gates every read.
  always_ff @(posedge clk_in) begin
    if (!rst_in && fill_word) begin
      data_arr[fill_idx][cnt] <= bus.miss_data;
      if (cnt == LAST_WORD) begin
        tag_arr[fill_idx] <= fill_tag;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit cycles and refill entries, free-running with natural wrap.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && rdy_in) begin
        hit_cnt <= hit_cnt + WORD_W'(1);
      end
      if (miss_start) begin
        miss_cnt <= miss_cnt + WORD_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: expected words/addresses are queued when the
// stimulus is driven and compared when the cache presents them.
module tb_icache;
  import icache_pkg::*;

  localparam int WORDS = 1 << ICACHE_OFFSET_BIT_DEF;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  icache_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .bus     (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_sb(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] word);
    @(negedge clk_in);
    bus.inst_req = 1'b1;
    bus.pc       = addr;
    exp_q.push_back(word);
    #1;
    check("hit_ready", 32'(bus.inst_ready), 32'd1);
    check_sb("hit_inst", bus.inst);
  endtask

  task automatic fetch_miss(input logic [31:0] addr);
    @(negedge clk_in);
    bus.inst_req = 1'b1;
    bus.pc       = addr;
    #1;
    check("miss_ready_low", 32'(bus.inst_ready), 32'd0);
    check("miss_inst_zero", bus.inst, 32'd0);
  endtask

  // Serve a full line; optional clear pulse and 3-cycle rdy_in stall at given words.
  task automatic refill(input logic [31:0] base, input logic [31:0] seed,
                        input int clear_at, input int stall_at);
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk_in);
      bus.inst_req   = 1'b0;
      bus.miss_ready = 1'b0;
      bus.clear      = 1'b0;
      if (k == stall_at) begin
        rdy_in         = 1'b0;
        bus.miss_ready = 1'b1;
        bus.miss_data  = 32'hDEAD_BEEF;
        for (int s = 0; s < 3; s++) begin
          exp_q.push_back(base + 32'(4 * k));
          #1;
          check_sb("stall_addr", bus.miss_addr);
          check("stall_busy", 32'(bus.mem_busy), 32'd1);
          @(negedge clk_in);
        end
        rdy_in = 1'b1;
      end
      if (k == clear_at) begin
        bus.clear    = 1'b1;
        bus.inst_req = 1'b1;
        bus.pc       = base + 32'(4 * k);
      end
      exp_q.push_back(base + 32'(4 * k));
      bus.miss_ready = 1'b1;
      bus.miss_data  = 32'(seed * 32'(k + 1));
      #1;
      check("refill_req", 32'(bus.miss_req), 32'd1);
      check_sb("refill_addr", bus.miss_addr);
      if (k == clear_at) check("clear_in_refill", 32'(bus.inst_ready), 32'd0);
    end
    @(negedge clk_in);
    bus.miss_ready = 1'b0;
    bus.clear      = 1'b0;
    bus.inst_req   = 1'b0;
    #1;
    check("refill_done_busy", 32'(bus.mem_busy), 32'd0);
    check("refill_done_req", 32'(bus.miss_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in         = 1'b1;
    rdy_in         = 1'b1;
    bus.inst_req   = 1'b0;
    bus.pc         = '0;
    bus.clear      = 1'b0;
    bus.miss_ready = 1'b0;
    bus.miss_data  = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rst_inst_ready", 32'(bus.inst_ready), 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_mem_busy", 32'(bus.mem_busy), 32'd0);
    check("rst_miss_req", 32'(bus.miss_req), 32'd0);
    check("rst_miss_addr", bus.miss_addr, 32'd0);

    // Cold miss on line 0, then hits.
    fetch_miss(32'h0);
    refill(32'h0, 32'h11, -1, -1);
    fetch_hit(32'h8, 32'h33);
    check("hit_no_miss_req", 32'(bus.miss_req), 32'd0);
    fetch_hit(32'h0, 32'h11);
    fetch_hit(32'hF, 32'h44);

    // Conflict on index 0 evicts the first line.
    fetch_miss(32'h100);
    refill(32'h100, 32'h55, -1, -1);
    fetch_hit(32'h104, 32'hAA);
    fetch_miss(32'h0);
    refill(32'h0, 32'h11, -1, -1);
    fetch_hit(32'h4, 32'h22);

    // Clear mid-refill does not abort; clear masks hits and blocks new misses.
    fetch_miss(32'h10);
    refill(32'h10, 32'h21, 2, -1);
    fetch_hit(32'h18, 32'h63);
    @(negedge clk_in);
    bus.inst_req = 1'b1;
    bus.pc       = 32'h18;
    bus.clear    = 1'b1;
    #1;
    check("clear_masks_hit", 32'(bus.inst_ready), 32'd0);
    check("clear_masks_inst", bus.inst, 32'd0);
    @(negedge clk_in);
    bus.pc = 32'h40;
    #1;
    check("clear_miss_ready", 32'(bus.inst_ready), 32'd0);
    @(negedge clk_in);
    bus.clear    = 1'b0;
    bus.inst_req = 1'b0;
    #1;
    check("clear_blocks_refill", 32'(bus.mem_busy), 32'd0);

    // rdy_in stall with miss_ready held high must not advance the refill.
    fetch_miss(32'h30);
    refill(32'h30, 32'h07, -1, 1);
    fetch_hit(32'h34, 32'h0E);
    fetch_hit(32'h3C, 32'h1C);

    // Reset in the middle of a refill.
    fetch_miss(32'h20);
    @(negedge clk_in);
    bus.inst_req   = 1'b0;
    bus.miss_ready = 1'b1;
    bus.miss_data  = 32'h9;
    exp_q.push_back(32'h20);
    #1;
    check_sb("rst_pre_addr0", bus.miss_addr);
    @(negedge clk_in);
    exp_q.push_back(32'h24);
    #1;
    check_sb("rst_pre_addr1", bus.miss_addr);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in         = 1'b0;
    bus.miss_ready = 1'b0;
    #1;
    check("midrst_miss_req", 32'(bus.miss_req), 32'd0);
    check("midrst_busy", 32'(bus.mem_busy), 32'd0);
    check("midrst_addr", bus.miss_addr, 32'd0);
`ifdef ICACHE_STATS_EN
    check("midrst_miss_cnt", miss_cnt, 32'd0);
    check("midrst_hit_cnt", hit_cnt, 32'd0);
`endif
    fetch_miss(32'h0);
    @(negedge clk_in);
    bus.inst_req = 1'b0;
    #1;
    check("post_rst_line0_busy", 32'(bus.mem_busy), 32'd1);
    refill(32'h0, 32'h3, -1, -1);
    fetch_miss(32'h20);
    refill(32'h20, 32'h09, -1, -1);
    fetch_hit(32'h28, 32'h1B);
    fetch_hit(32'h8, 32'h9);
`ifdef ICACHE_STATS_EN
    @(negedge clk_in);
    bus.inst_req = 1'b0;
    #1;
    check("final_miss_cnt", miss_cnt, 32'd2);
    check("final_hit_cnt", hit_cnt, 32'd2);
`endif

    @(negedge clk_in);
    bus.inst_req = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter ICACHE_INDEX_BIT, default 4, log2 line count (16 lines).
REQ-002 SHALL have parameter ICACHE_OFFSET_BIT, default 2, log2 words per line (4 words, 16 bytes).
REQ-003 SHALL have ports clk_in  in  1  single clock; rst_in  in  1  reset, synchronous, active-high; rdy_in  in  1  pause when low.
REQ-004 SHALL have ports inst_req  in  1  fetch request from instruction unit; pc  in  32  fetch address.
REQ-005 SHALL have ports inst_ready  out  1  hit this cycle; inst  out  32  instruction word; mem_busy  out  1  refill in progress.
REQ-006 SHALL have port clear  in  1  pipeline flush from ROB.
REQ-007 SHALL have ports miss_req  out  1  word request to memory unit; miss_addr  out  32  word address; miss_ready  in  1  word returned; miss_data  in  32  returned word.

Function
REQ-008 SHALL split pc: bits [1:0] ignored; offset = pc[OFF+1:2]; index = pc[IDX+OFF+1:OFF+2]; tag = pc[31:IDX+OFF+2].
REQ-009 SHALL hold per line one valid bit, one tag, 2^OFF data words, all in registers.
REQ-010 SHALL assert inst_ready combinationally, same cycle, when inst_req && state==IDLE && valid[index] && tag match && !clear; inst = data[index][offset] then.
REQ-011 SHALL drive inst_ready=0 and inst=0 whenever the hit condition is false.
REQ-012 SHALL have FSM states IDLE and REFILL; mem_busy = (state==REFILL).
REQ-013 SHALL, in IDLE on a miss (inst_req, no hit, !clear, rdy_in), latch line base (pc with offset and bits [1:0] zeroed), clear valid[index], reset word counter to 0, enter REFILL.
REQ-014 SHALL, in REFILL, hold miss_req=1 and miss_addr = base + 4*counter until miss_ready; miss_req=0 in IDLE.
REQ-015 SHALL, on miss_ready, write miss_data to data[index][counter] and increment counter; counter wraps only via return to IDLE.
REQ-016 SHALL, on miss_ready with counter == 2^OFF-1, write tag, set valid[index], return to IDLE next cycle; first hit on that line the cycle after.
REQ-017 SHALL ignore miss_ready in IDLE.
REQ-018 SHALL NOT abort a refill on clear; the line completes and becomes valid; clear only masks inst_ready and blocks starting a new refill that cycle.
REQ-019 SHALL freeze all state (FSM, counter, arrays) while rdy_in low; combinational outputs still reflect current state.
REQ-020 SHALL ignore inst_req and pc during REFILL (no second miss queued).

Reset
REQ-021 SHALL, on rst_in high at clk_in edge, clear all valid bits, state=IDLE, counter=0, latched base=0; outputs inst_ready=0, inst=0, mem_busy=0, miss_req=0, miss_addr=0.
REQ-022 SHALL give reset priority over rdy_in, clear and miss_ready; reset mid-refill drops the refill and leaves that line invalid.
REQ-023 SHALL leave tag and data arrays uninitialised by reset (gated by valid).

Configuration
REQ-024 SHALL support macro ICACHE_STATS_EN: when defined, outputs hit_cnt  out  32 and miss_cnt  out  32, incrementing on each hit cycle (rdy_in high) and each REFILL entry, reset to 0, wrapping at 2^32.
REQ-025 SHALL, without ICACHE_STATS_EN, omit those ports and counters entirely; behaviour otherwise identical.

Structure
REQ-026 SHALL take ICACHE_INDEX_BIT, ICACHE_OFFSET_BIT defaults and state encodings from shared const.v alongside existing ROB/PRED constants.
REQ-027 SHALL be a single module; no sub-module (tag compare is inline).

Verification
REQ-028 Reset, then inst_req=1 pc=0x0 -> inst_ready=0, mem_busy=1 next cycle, miss_addr 0x0,0x4,0x8,0xC in turn as miss_ready pulses.
REQ-029 After REQ-028 refill with data 0x11..0x44, pc=0x8 -> inst_ready=1 same cycle, inst=0x33, no miss_req.
REQ-030 pc=0x100 (same index 0, tag differs) after line 0 valid -> miss, refill of 0x100-0x10C, then pc=0x0 misses again (eviction).
REQ-031 clear=1 during REFILL at counter=2 -> refill completes, valid set; clear=1 with hitting pc -> inst_ready=0.
REQ-032 rdy_in=0 for 3 cycles mid-refill with miss_ready high -> counter unchanged; resumes correctly when rdy_in=1.
REQ-033 rst_in=1 at counter=1 -> state IDLE, miss_req=0, that line's next access misses; with ICACHE_STATS_EN, miss_cnt=0 after reset.
